// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: timing bundle, screen size and default colour key.
package vga_pkg;

    localparam int unsigned HOR_PIXELS  = 800;
    localparam int unsigned VER_PIXELS  = 600;
    localparam logic [11:0] KEY_RGB_DEF = 12'hF0F;

    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
    } vga_tim_t;

endpackage

// File: rtl/sprite_draw_pos_latch.sv
// Sprite position holding: pending/active registers, updated only on the rising edge of vblnk.
module sprite_pos_latch #(
    parameter int unsigned X_RST = 0,
    parameter int unsigned Y_RST = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblnk,
    input  logic        pos_valid,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    output logic [10:0] x_act,
    output logic [10:0] y_act
);

    logic [10:0] x_pend;
    logic [10:0] y_pend;
    logic        pending;
    logic        vblnk_prev;
    logic        vblnk_rise;

    assign vblnk_rise = vblnk && !vblnk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pend     <= '0;
            y_pend     <= '0;
            pending    <= 1'b0;
            vblnk_prev <= 1'b0;
            x_act      <= 11'(X_RST);
            y_act      <= 11'(Y_RST);
        end else begin
            vblnk_prev <= vblnk;
            if (vblnk_rise) begin
                // A strobe on the edge itself bypasses the pending stage.
                pending <= 1'b0;
                if (pos_valid) begin
                    x_act <= xpos;
                    y_act <= ypos;
                end else if (pending) begin
                    x_act <= x_pend;
                    y_act <= y_pend;
                end
            end else if (pos_valid) begin
                x_pend  <= xpos;
                y_pend  <= ypos;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_draw.sv
// Sprite overlay stage: ROM address generation, 3-cycle timing delay, colour-key compositing.
module sprite_draw
    import vga_pkg::*;
#(
    parameter int unsigned SPR_W   = 48,
    parameter int unsigned SPR_H   = 64,
    parameter int unsigned AX_BITS = 6,
    parameter int unsigned AY_BITS = 6,
    parameter logic [11:0] KEY_RGB = KEY_RGB_DEF,
    parameter int unsigned X_RST   = 0,
    parameter int unsigned Y_RST   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [10:0]                hcount_in,
    input  logic                       hsync_in,
    input  logic                       hblnk_in,
    input  logic [10:0]                vcount_in,
    input  logic                       vsync_in,
    input  logic                       vblnk_in,
    input  logic [11:0]                rgb_in,
    input  logic [10:0]                xpos,
    input  logic [10:0]                ypos,
    input  logic                       pos_valid,
    input  logic                       enable,
    output logic [AY_BITS+AX_BITS-1:0] rom_addr,
    input  logic [11:0]                rom_rgb,
    output logic [10:0]                hcount_out,
    output logic                       hsync_out,
    output logic                       hblnk_out,
    output logic [10:0]                vcount_out,
    output logic                       vsync_out,
    output logic                       vblnk_out,
    output logic [11:0]                rgb_out
);

    logic [10:0] x_act;
    logic [10:0] y_act;

    sprite_pos_latch #(
        .X_RST(X_RST),
        .Y_RST(Y_RST)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .vblnk    (vblnk_in),
        .pos_valid(pos_valid),
        .xpos     (xpos),
        .ypos     (ypos),
        .x_act    (x_act),
        .y_act    (y_act)
    );

    vga_tim_t           tim_in, tim1, tim2, tim3;
    logic [11:0]        rgb1, rgb2;
    logic               in1, in2;
    logic [11:0]        x_lo, x_hi, y_lo, y_hi;
    logic               inside_c;
    logic [AX_BITS-1:0] dx;
    logic [AY_BITS-1:0] dy;

    // 12-bit bounds keep x_act+SPR_W from wrapping, so edge sprites clip instead.
    always_comb begin
        tim_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                   vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};
        x_lo     = {1'b0, x_act};
        x_hi     = x_lo + 12'(SPR_W);
        y_lo     = {1'b0, y_act};
        y_hi     = y_lo + 12'(SPR_H);
        inside_c = enable
                && ({1'b0, hcount_in} >= x_lo) && ({1'b0, hcount_in} < x_hi)
                && ({1'b0, vcount_in} >= y_lo) && ({1'b0, vcount_in} < y_hi);
        dx       = AX_BITS'(hcount_in - x_act);
        dy       = AY_BITS'(vcount_in - y_act);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tim1     <= '0;
            rgb1     <= '0;
            in1      <= 1'b0;
            rom_addr <= '0;
            tim2     <= '0;
            rgb2     <= '0;
            in2      <= 1'b0;
            tim3     <= '0;
            rgb_out  <= '0;
        end else begin
            tim1     <= tim_in;
            rgb1     <= rgb_in;
            in1      <= inside_c;
            rom_addr <= inside_c ? {dy, dx} : '0;

            tim2     <= tim1;
            rgb2     <= rgb1;
            in2      <= in1;

            // rom_rgb here belongs to the pixel now held in stage 2.
            tim3     <= tim2;
            if (tim2.hblnk || tim2.vblnk)
                rgb_out <= 12'h000;
            else if (in2 && rom_rgb != KEY_RGB)
                rgb_out <= rom_rgb;
            else
                rgb_out <= rgb2;
        end
    end

    assign hcount_out = tim3.hcount;
    assign hsync_out  = tim3.hsync;
    assign hblnk_out  = tim3.hblnk;
    assign vcount_out = tim3.vcount;
    assign vsync_out  = tim3.vsync;
    assign vblnk_out  = tim3.vblnk;

endmodule
